// File: rtl/wb_write_queue.sv
// Writeback queue feeding the register-file write port in program order,
// with youngest-match forwarding of pending results to the decode read ports.
module wb_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_rd,
  input  logic [31:0]   in_data,
  input  logic          hold,
  output logic [4:0]    A3,
  output logic [31:0]   WD,
  output logic          RegWrite,
  input  logic [4:0]    fwd_rs1,
  input  logic [4:0]    fwd_rs2,
  output logic          fwd_hit1,
  output logic [31:0]   fwd_data1,
  output logic          fwd_hit2,
  output logic [31:0]   fwd_data2,
  output logic [AW:0]   count
);

  localparam int unsigned CW = AW + 1;

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          store;
  logic          retire;
  logic          empty;
  logic [AW-1:0] idx;

  assign empty    = (count == '0);
  assign in_ready = ~RST & (count != CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  // Writes to x0 are consumed but never queued.
  assign store    = accept & (in_rd != 5'd0);
  assign retire   = ~empty & ~hold;

  assign RegWrite = retire;
  assign A3       = empty ? 5'd0  : mem_rd[rd_ptr];
  assign WD       = empty ? 32'd0 : mem_data[rd_ptr];

  // Pointer and occupancy state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store)  wr_ptr <= wr_ptr + AW'(1);
      if (retire) rd_ptr <= rd_ptr + AW'(1);
      case ({store, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below count.
  always_ff @(posedge CLK) begin
    if (store && !RST) begin
      mem_rd[wr_ptr]   <= in_rd;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (CW'(i) < count) begin
        if ((fwd_rs1 != 5'd0) && (mem_rd[idx] == fwd_rs1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem_data[idx];
        end
        if ((fwd_rs2 != 5'd0) && (mem_rd[idx] == fwd_rs2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: a queue-based reference model predicts
// state each cycle, and a monitor checks every register-file write in order.
module tb_wb_write_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } entry_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0;
  logic        hold = 1'b1;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        RegWrite;
  logic [4:0]  fwd_rs1 = '0;
  logic [4:0]  fwd_rs2 = '0;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic [AW:0] count;

  wb_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .hold(hold), .A3(A3), .WD(WD),
    .RegWrite(RegWrite), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2),
    .fwd_data2(fwd_data2), .count(count)
  );

  always #5 CLK = ~CLK;

  entry_t      mq[$];     // pending entries as the model sees them
  entry_t      exp_q[$];  // writes the monitor expects, in order
  logic [31:0] rf [32];   // register file as written by the DUT
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [4:0] rs, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 5'd0)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].rd == rs) begin
          hit = 1'b1;
          d   = mq[i].d;
          break;
        end
  endfunction

  // One clock of stimulus, checks of combinational outputs, then model update.
  task automatic cycle(input bit v, input logic [4:0] rd, input logic [31:0] d, input bit h,
                       input logic [4:0] r1, input logic [4:0] r2, input bit rst);
    logic        e_rdy, e_ret, h1, h2;
    logic [31:0] d1, d2;
    @(negedge CLK);
    RST = rst; in_valid = v; in_rd = rd; in_data = d; hold = h;
    fwd_rs1 = r1; fwd_rs2 = r2;
    #1;
    e_rdy = !rst && (mq.size() != DEPTH);
    e_ret = (mq.size() != 0) && !h;
    lookup(r1, h1, d1);
    lookup(r2, h2, d2);
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("count", 32'(count), 32'(mq.size()));
    chk("RegWrite", 32'(RegWrite), 32'(e_ret));
    chk("fwd_hit1", 32'(fwd_hit1), 32'(h1));
    chk("fwd_data1", fwd_data1, d1);
    chk("fwd_hit2", 32'(fwd_hit2), 32'(h2));
    chk("fwd_data2", fwd_data2, d2);
    if (mq.size() == 0) begin
      chk("A3_idle", 32'(A3), 32'd0);
      chk("WD_idle", WD, 32'd0);
    end
    if (rst) begin
      mq.delete();
      exp_q.delete();
    end else begin
      if (e_ret) void'(mq.pop_front());
      if (v && e_rdy && rd != 5'd0) begin
        mq.push_back('{rd: rd, d: d});
        exp_q.push_back('{rd: rd, d: d});
      end
    end
  endtask

  task automatic idle(input bit h, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, h, 5'd0, 5'd0, 1'b0);
  endtask

  // Monitor: every retiring write must match the oldest expected entry.
  initial begin
    entry_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (RegWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(A3), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("A3", 32'(A3), 32'(e.rd));
          chk("WD", WD, e.d);
        end
        rf[A3] = WD;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset held two edges with in_valid high.
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd0, 5'd0, 1'b1);
    idle(1'b0, 1);

    // Single write of x1.
    cycle(1'b1, 5'd1, 32'd30, 1'b0, 5'd1, 5'd0, 1'b0);
    idle(1'b0, 3);
    chk("rf_x1", rf[1], 32'd30);

    // Fill under hold, overflow attempt, then ordered drain.
    cycle(1'b1, 5'd2, 32'd15, 1'b1, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 5'd3, 32'd25, 1'b1, 5'd2, 5'd0, 1'b0);
    cycle(1'b1, 5'd4, 32'd5,  1'b1, 5'd3, 5'd2, 1'b0);
    cycle(1'b1, 5'd5, 32'd18, 1'b1, 5'd4, 5'd5, 1'b0);
    cycle(1'b1, 5'd6, 32'd4,  1'b1, 5'd5, 5'd6, 1'b0);
    cycle(1'b1, 5'd6, 32'd4,  1'b0, 5'd2, 5'd6, 1'b0);
    idle(1'b0, 5);

    // x0 write is consumed without effect.
    cycle(1'b1, 5'd0, 32'd18, 1'b0, 5'd0, 5'd0, 1'b0);
    idle(1'b0, 2);
    chk("rf_x0", rf[0], 32'd0);

    // Youngest match wins.
    cycle(1'b1, 5'd3, 32'd25, 1'b1, 5'd3, 5'd0, 1'b0);
    cycle(1'b1, 5'd3, 32'd99, 1'b1, 5'd3, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0,  1'b1, 5'd3, 5'd0, 1'b0);

    // Simultaneous accept and retire, then mid-operation reset.
    cycle(1'b1, 5'd6, 32'd4, 1'b0, 5'd6, 5'd3, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd3, 1'b1);
    idle(1'b0, 3);

    // Randomized traffic; reset cycles hold off retirement.
    for (int n = 0; n < 600; n++) begin
      bit r, v, h;
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 9) < 7);
      h = r || ($urandom_range(0, 9) < 3);
      cycle(v, 5'($urandom_range(0, 7)), $urandom, h,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r);
    end

    idle(1'b0, DEPTH + 2);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
